// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared car FSM encoding, car_state field offsets and default
//               building dimensions for the elevator car/control blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        CAR_IDLE = 2'd0,
        CAR_MOVE = 2'd1,
        CAR_DOOR = 2'd2
    } car_fsm_e;

    // Layout of the packed car_state word consumed by prioritizer and display
    localparam int STATE_FLOOR_LSB  = 2;
    localparam int STATE_MOVING_BIT = 1;
    localparam int STATE_DIR_BIT    = 0;

    localparam int DEFAULT_FLOORS  = 10;
    localparam int DEFAULT_FLOOR_W = 4;

endpackage
`default_nettype wire

// File: rtl/pending_scan.sv
`default_nettype none
// ============================================================================
// Module      : pending_scan
// Description : Reports whether any pending call lies above, below or at a
//               given floor. Shared by the car controller and control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module pending_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS  = DEFAULT_FLOORS,
    parameter int FLOOR_W = DEFAULT_FLOOR_W
) (
    input  logic [FLOORS-1:0]  pending,
    input  logic [FLOOR_W-1:0] floor,
    output logic               any_above,
    output logic               any_below,
    output logic               hit
);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        hit       = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i]) begin
                if (FLOOR_W'(i) > floor) any_above = 1'b1;
                if (FLOOR_W'(i) < floor) any_below = 1'b1;
                if (FLOOR_W'(i) == floor) hit = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elevator_car_ctrl
// Description : Single-car controller with latched calls, SCAN scheduling,
//               multi-cycle floor travel and a holdable door dwell timer.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS        = DEFAULT_FLOORS,
    parameter int FLOOR_W       = DEFAULT_FLOOR_W,
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               call_valid,
    input  logic [FLOOR_W-1:0] call_floor,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] floor,
    output logic               moving,
    output logic               up_down,
    output logic               door_open,
    output logic [FLOORS-1:0]  pending,
    output logic [FLOOR_W+1:0] car_state
);

    localparam int C_TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int C_TIMER_W   = $clog2(C_TIMER_MAX + 1);
    localparam logic [C_TIMER_W-1:0] C_TRAVEL  = C_TIMER_W'(TRAVEL_CYCLES);
    localparam logic [C_TIMER_W-1:0] C_DOOR    = C_TIMER_W'(DOOR_CYCLES);
    localparam logic [C_TIMER_W-1:0] C_ONE     = C_TIMER_W'(1);
    localparam logic [FLOOR_W:0]     C_FLOORS  = (FLOOR_W+1)'(FLOORS);

    car_fsm_e               r_state;
    logic [C_TIMER_W-1:0]   r_timer;
    logic [FLOOR_W-1:0]     r_floor;
    logic                   r_up_down;
    logic                   r_moving;
    logic                   r_door_open;
    logic [FLOORS-1:0]      r_pending;

    logic                   w_call_ok;
    logic                   w_call_here;
    logic                   w_arrive;
    logic [FLOOR_W-1:0]     w_step_floor;
    logic [FLOOR_W-1:0]     w_clr_floor;
    logic                   w_clr_en;
    logic [FLOORS-1:0]      w_set;
    logic [FLOORS-1:0]      w_clr;
    logic                   w_above_cur;
    logic                   w_below_cur;
    logic                   w_hit_cur;
    logic                   w_above_nxt;
    logic                   w_below_nxt;
    logic                   w_hit_nxt;
    logic                   w_go_up;
    logic                   w_ahead_nxt;

    pending_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan_cur (
        .pending   (r_pending),
        .floor     (r_floor),
        .any_above (w_above_cur),
        .any_below (w_below_cur),
        .hit       (w_hit_cur)
    );

    // Arrival is judged against the floor the car is about to enter
    pending_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan_nxt (
        .pending   (r_pending),
        .floor     (w_step_floor),
        .any_above (w_above_nxt),
        .any_below (w_below_nxt),
        .hit       (w_hit_nxt)
    );

    assign w_call_ok    = call_valid && ({1'b0, call_floor} < C_FLOORS);
    assign w_call_here  = w_call_ok && (call_floor == r_floor) && (r_state == CAR_DOOR);
    assign w_arrive     = (r_state == CAR_MOVE) && (r_timer == C_ONE);
    assign w_step_floor = r_up_down ? (r_floor + FLOOR_W'(1)) : (r_floor - FLOOR_W'(1));
    assign w_clr_floor  = w_arrive ? w_step_floor : r_floor;
    assign w_clr_en     = ((r_state == CAR_IDLE) && w_hit_cur) || (w_arrive && w_hit_nxt);
    assign w_go_up      = (r_up_down & w_above_cur) | (~r_up_down & ~w_below_cur & w_above_cur);
    assign w_ahead_nxt  = r_up_down ? w_above_nxt : w_below_nxt;

    // A new call for the floor being served this edge is absorbed by the clear
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < FLOORS; i++) begin
            w_set[i] = w_call_ok && !w_call_here && (call_floor == FLOOR_W'(i));
            w_clr[i] = w_clr_en && (w_clr_floor == FLOOR_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CAR_IDLE;
            r_timer     <= '0;
            r_floor     <= '0;
            r_up_down   <= 1'b1;
            r_moving    <= 1'b0;
            r_door_open <= 1'b0;
            r_pending   <= '0;
        end else begin
            r_pending <= (r_pending | w_set) & ~w_clr;
            case (r_state)
                CAR_IDLE: begin
                    if (w_hit_cur) begin
                        r_state     <= CAR_DOOR;
                        r_door_open <= 1'b1;
                        r_timer     <= C_DOOR;
                    end else if (w_go_up) begin
                        r_state   <= CAR_MOVE;
                        r_moving  <= 1'b1;
                        r_up_down <= 1'b1;
                        r_timer   <= C_TRAVEL;
                    end else if (w_below_cur) begin
                        r_state   <= CAR_MOVE;
                        r_moving  <= 1'b1;
                        r_up_down <= 1'b0;
                        r_timer   <= C_TRAVEL;
                    end
                end
                CAR_MOVE: begin
                    r_timer <= r_timer - C_ONE;
                    if (w_arrive) begin
                        r_floor <= w_step_floor;
                        if (w_hit_nxt) begin
                            r_state     <= CAR_DOOR;
                            r_moving    <= 1'b0;
                            r_door_open <= 1'b1;
                            r_timer     <= C_DOOR;
                        end else if (w_ahead_nxt) begin
                            r_timer <= C_TRAVEL;
                        end else begin
                            r_state  <= CAR_IDLE;
                            r_moving <= 1'b0;
                        end
                    end
                end
                CAR_DOOR: begin
                    if (door_hold || w_call_here) begin
                        r_timer <= C_DOOR;
                    end else if (r_timer == C_ONE) begin
                        r_state     <= CAR_IDLE;
                        r_door_open <= 1'b0;
                        r_timer     <= '0;
                    end else begin
                        r_timer <= r_timer - C_ONE;
                    end
                end
                default: begin
                    r_state     <= CAR_IDLE;
                    r_moving    <= 1'b0;
                    r_door_open <= 1'b0;
                    r_timer     <= '0;
                end
            endcase
        end
    end

    assign floor     = r_floor;
    assign moving    = r_moving;
    assign up_down   = r_up_down;
    assign door_open = r_door_open;
    assign pending   = r_pending;

    always_comb begin
        car_state                                   = '0;
        car_state[STATE_FLOOR_LSB +: FLOOR_W]       = r_floor;
        car_state[STATE_MOVING_BIT]                 = r_moving;
        car_state[STATE_DIR_BIT]                    = r_up_down;
    end

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_car_ctrl
// Description : Directed scenarios plus random calls/holds/resets, checked
//               cycle by cycle against a behavioural car model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_car_ctrl;

    localparam int FLOORS        = 10;
    localparam int FLOOR_W       = 4;
    localparam int TRAVEL_CYCLES = 2;
    localparam int DOOR_CYCLES   = 3;
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               call_valid = 1'b0;
    logic [FLOOR_W-1:0] call_floor = '0;
    logic               door_hold = 1'b0;
    logic [FLOOR_W-1:0] floor;
    logic               moving;
    logic               up_down;
    logic               door_open;
    logic [FLOORS-1:0]  pending;
    logic [FLOOR_W+1:0] car_state;

    int n_chk = 0;
    int n_err = 0;

    int m_floor, m_dir, m_mode, m_timer;
    bit m_pend [FLOORS];

    int q_stops [$];
    int q_dirs  [$];
    bit prev_door;

    elevator_car_ctrl #(
        .FLOORS        (FLOORS),
        .FLOOR_W       (FLOOR_W),
        .TRAVEL_CYCLES (TRAVEL_CYCLES),
        .DOOR_CYCLES   (DOOR_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .call_valid (call_valid),
        .call_floor (call_floor),
        .door_hold  (door_hold),
        .floor      (floor),
        .moving     (moving),
        .up_down    (up_down),
        .door_open  (door_open),
        .pending    (pending),
        .car_state  (car_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit calls_above(input int f);
        for (int i = f + 1; i < FLOORS; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit calls_below(input int f);
        for (int i = 0; i < f; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < FLOORS; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Next-state of the car from the rules, given the inputs seen at this edge
    task automatic model_step(input bit cv, input int cf, input bit hold, input bit rst);
        int  served;
        bit  in_range;
        bit  reopen;
        int  nf;
        if (rst) begin
            m_floor = 0; m_dir = 1; m_mode = M_IDLE; m_timer = 0;
            for (int i = 0; i < FLOORS; i++) m_pend[i] = 1'b0;
            return;
        end
        served   = -1;
        in_range = cv && (cf < FLOORS);
        reopen   = in_range && (m_mode == M_DOOR) && (cf == m_floor);
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    served = m_floor; m_mode = M_DOOR; m_timer = DOOR_CYCLES;
                end else if ((m_dir == 1 && calls_above(m_floor)) ||
                             (m_dir == 0 && !calls_below(m_floor) && calls_above(m_floor))) begin
                    m_dir = 1; m_mode = M_MOVE; m_timer = TRAVEL_CYCLES;
                end else if (calls_below(m_floor)) begin
                    m_dir = 0; m_mode = M_MOVE; m_timer = TRAVEL_CYCLES;
                end
            end
            M_MOVE: begin
                if (m_timer == 1) begin
                    nf = (m_dir == 1) ? m_floor + 1 : m_floor - 1;
                    m_floor = nf;
                    if (m_pend[nf]) begin
                        served = nf; m_mode = M_DOOR; m_timer = DOOR_CYCLES;
                    end else if ((m_dir == 1) ? calls_above(nf) : calls_below(nf)) begin
                        m_timer = TRAVEL_CYCLES;
                    end else begin
                        m_mode = M_IDLE; m_timer = 0;
                    end
                end else begin
                    m_timer--;
                end
            end
            default: begin
                if (hold || reopen) m_timer = DOOR_CYCLES;
                else if (m_timer == 1) begin m_mode = M_IDLE; m_timer = 0; end
                else m_timer--;
            end
        endcase
        if (in_range && !reopen && cf != served) m_pend[cf] = 1'b1;
        if (served >= 0) m_pend[served] = 1'b0;
    endtask

    task automatic compare_all();
        logic [FLOORS-1:0]  p;
        logic [FLOOR_W+1:0] cs;
        for (int i = 0; i < FLOORS; i++) p[i] = m_pend[i];
        cs = {FLOOR_W'(m_floor), m_mode == M_MOVE, m_dir[0]};
        check("floor", floor, m_floor);
        check("moving", moving, m_mode == M_MOVE);
        check("up_down", up_down, m_dir);
        check("door_open", door_open, m_mode == M_DOOR);
        check("pending", pending, p);
        check("car_state", car_state, cs);
    endtask

    task automatic step(input bit cv, input int cf, input bit hold, input bit rst);
        call_valid = cv;
        call_floor = FLOOR_W'(cf);
        door_hold  = hold;
        reset      = rst;
        model_step(cv, cf, hold, rst);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic track();
        if (door_open && !prev_door) begin
            q_stops.push_back(int'(floor));
            q_dirs.push_back(int'(up_down));
        end
        prev_door = door_open;
    endtask

    initial begin
        int cnt;
        bit inj, done, found;
        int exp_stops [3] = '{7, 8, 3};
        int exp_dirs  [3] = '{1, 1, 0};

        // Reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_car_state", car_state, 6'b000001);

        // Call 9 from floor 0
        step(1, 9, 0, 0);
        check("lat_pend9", pending, 10'h200);
        check("lat_moving0", moving, 1'b0);
        step(0, 0, 0, 0);
        check("lat_moving1", moving, 1'b1);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(0, 0, 0, 0);
            if (door_open) cnt++;
        end
        check("s2_floor", floor, 9);
        check("s2_door_cycles", cnt, 3);
        check("s2_pending", pending, 0);

        // SCAN ordering
        step(0, 0, 0, 1);
        q_stops.delete(); q_dirs.delete();
        prev_door = 1'b0; inj = 1'b0; done = 1'b0;
        step(1, 8, 0, 0);
        for (int k = 0; k < 100 && !done; k++) begin
            if (!inj && m_floor == 5 && m_mode == M_MOVE) begin
                step(1, 3, 0, 0);
                track();
                step(1, 7, 0, 0);
                inj = 1'b1;
            end else begin
                step(0, 0, 0, 0);
            end
            track();
            if (inj && m_mode == M_IDLE && !any_pend()) done = 1'b1;
        end
        check("s3_done", done, 1'b1);
        check("s3_nstops", q_stops.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("s3_stop", (i < q_stops.size()) ? q_stops[i] : 32'hff, exp_stops[i]);
            check("s3_dir", (i < q_dirs.size()) ? q_dirs[i] : 32'hff, exp_dirs[i]);
        end

        // Same-floor call and door extension at floor 4
        step(0, 0, 0, 1);
        step(1, 4, 0, 0);
        for (int k = 0; k < 30; k++) step(0, 0, 0, 0);
        check("s4_at4", floor, 4);
        step(1, 4, 0, 0);
        cnt = 0;
        step(0, 0, 0, 0);
        if (door_open) cnt++;
        step(1, 4, 0, 0);
        if (door_open) cnt++;
        check("s4_no_relatch", pending, 0);
        step(0, 0, 1, 0);
        if (door_open) cnt++;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0);
            if (door_open) cnt++;
        end
        check("s4_door_cycles", cnt, 5);

        // Out-of-range calls
        step(1, 10, 0, 0);
        step(1, 15, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
        check("s5_pending", pending, 0);
        check("s5_moving", moving, 1'b0);
        check("s5_floor", floor, 4);

        // Reset while moving
        step(0, 0, 0, 1);
        step(1, 2, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 0);
        step(1, 6, 0, 0);
        step(1, 9, 0, 0);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_floor == 4 && m_mode == M_MOVE) found = 1'b1;
            else step(0, 0, 0, 0);
        end
        check("s6_reached4", found, 1'b1);
        check("s6_pend_69", pending, 10'h240);
        step(0, 0, 0, 1);
        check("s6_floor", floor, 0);
        check("s6_pending", pending, 0);
        check("s6_moving", moving, 1'b0);
        check("s6_door", door_open, 1'b0);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
